// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and prefetch FIFO feeding decode with redirect flush.
// Optional FETCH_BOUND_CHECK_EN stops fetching past IMEM_WORDS and raises sticky fetch_fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        fetch_fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || IMEM_WORDS == 0)
    $error("fetch_unit: FIFO_DEPTH must be a power of 2 >= 2 and IMEM_WORDS nonzero");
  logic [31:0]   pc;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc_mem [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic          pop, push, fault_block;
`ifdef FETCH_BOUND_CHECK_EN
  logic fault;
  assign fault_block = {2'b00, pc[31:2]} >= IMEM_WORDS;
  assign fetch_fault = fault;
  always_ff @(posedge clk)
    if (rst || redirect_valid) fault <= 1'b0;
    else if (fault_block) fault <= 1'b1;
`else
  assign fault_block = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  assign imem_addr = pc;
  assign id_valid  = count != '0;
  assign id_pc     = pc_mem[rd_ptr];
  assign id_instr  = instr_mem[rd_ptr];
  assign pop  = id_valid && id_ready;
  assign push = !redirect_valid && (count < (AW+1)'(FIFO_DEPTH) || pop) && !fault_block;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & ~32'h3;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= pc;
        instr_mem[wr_ptr] <= imem_instr;
        wr_ptr            <= wr_ptr + 1'b1;
        pc                <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch ordering, backpressure, redirect, wrap and reset.
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] imem_addr, imem_instr, redirect_pc = '0, id_instr, id_pc;
  logic id_valid, fetch_fault;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 :
           a == 32'h8 ? 32'h0020_81B3 : ~a;
  endfunction
  assign imem_instr = mem(imem_addr);

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .IMEM_WORDS(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_ready(id_ready), .fetch_fault(fetch_fault));

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [31:0] p);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"}, id_pc, p);
    chk({tag, "_instr"}, id_instr, mem(p));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    id_ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    step();
`ifdef FETCH_BOUND_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      head($sformatf("bnd%0d", i), 32'(4 * i));
      chk("bnd_nofault", 32'(fetch_fault), 32'd0);
      step();
    end
    chk("bnd_fault", 32'(fetch_fault), 32'd1);
    chk("bnd_empty", 32'(id_valid), 32'd0);
    chk("bnd_addr", imem_addr, 32'h10);
    step(2);
    chk("bnd_sticky", 32'(fetch_fault), 32'd1);
    chk("bnd_hold", imem_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("bnd_clear", 32'(fetch_fault), 32'd0);
    chk("bnd_raddr", imem_addr, 32'h0);
    step();
    head("bnd_refetch", 32'h0);
`else
    for (int i = 0; i < 3; i++) begin
      head($sformatf("stream%0d", i), 32'(4 * i));
      step();
    end
    id_ready = 1'b0;
    do_reset();
    step(10);
    chk("stall_addr", imem_addr, 32'h10);
    head("stall_head", 32'h0);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      head($sformatf("drain%0d", i), 32'(4 * i));
      step();
    end
    id_ready = 1'b0;
    do_reset();
    step(4);
    chk("full_addr", imem_addr, 32'h10);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_addr", imem_addr, 32'h40);
    step();
    head("tgt0", 32'h40);
    step();
    head("tgt1", 32'h44);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFD;
    step();
    redirect_valid = 1'b0;
    chk("wrap_flush", 32'(id_valid), 32'd0);
    step();
    head("wrap_top", 32'hFFFF_FFFC);
    step();
    head("wrap_zero", 32'h0);
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    step();
    redirect_valid = 1'b0;
    step(3);
    chk("pre_rst_addr", imem_addr, 32'h20);
    head("pre_rst_head", 32'h14);
    do_reset();
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_fault", 32'(fetch_fault), 32'd0);
    step();
    head("post_rst", 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the PC and drives imem_addr. Captures the combinationally returned instruction together with its PC into a small prefetch FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Accepts branch/jump redirects, which flush all buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 4, prefetch entries; power of 2, minimum 2.
- IMEM_WORDS, 256, instruction memory size in 32-bit words. Used only under FETCH_BOUND_CHECK_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_addr  output  32  fetch address to instruction memory; equals the current PC.
- imem_instr  input  32  instruction returned combinationally for imem_addr in the same cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target PC; bits [1:0] are ignored and treated as 0.
- id_valid  output  1  FIFO head holds a valid instruction.
- id_instr  output  32  instruction at FIFO head.
- id_pc  output  32  PC of the instruction at FIFO head.
- id_ready  input  1  decode accepts the head this cycle.
- fetch_fault  output  1  out-of-range fetch detected; sticky. Tied 0 without FETCH_BOUND_CHECK_EN.

Behaviour:
- Reset (rst=1 at posedge, including mid-operation):
  - pc <= RESET_PC; FIFO count, read pointer and write pointer <= 0; fetch_fault <= 0.
  - id_valid therefore reads 0 in the cycle after reset.
  - All buffered entries are discarded.
- imem_addr = pc, combinational from the pc register.
- pop = id_valid && id_ready.
- push = !redirect_valid && (count < FIFO_DEPTH || pop) && !fault_block.
  - fault_block is 0 without the feature.
- On push:
  - Write {pc, imem_instr} at the write pointer.
  - pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Without push and without redirect, pc holds.
- Full FIFO with simultaneous pop: push proceeds and count is unchanged.
- Empty FIFO: no pop is possible; push-only gives count+1.
- Redirect has priority over all other events in its cycle:
  - count and pointers <= 0, so every buffered entry is flushed.
  - Any pop that cycle is void: decode must also discard what it saw, and the block ignores id_ready.
  - pc <= {redirect_pc[31:2], 2'b00}; no push that cycle.
  - fetch_fault <= 0.
- Latency: an instruction fetched at posedge N into an empty FIFO appears at the head (id_valid=1) in cycle N+1.
  - Steady state with id_ready held high: one instruction per cycle, no bubbles.
- The first instruction at the redirect target is visible 2 cycles after the redirect cycle: redirect edge, then fetch edge.
- id_instr and id_pc are driven combinationally from the head entry. Their value is don't-care when id_valid=0.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- No combinational path from id_ready to imem_addr.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- Defined:
  - fault_block = (pc[31:2] >= IMEM_WORDS).
  - When fault_block is 1: no push, and fetch_fault <= 1, sticky until redirect or reset.
  - Entries already buffered still drain normally.
- Undefined:
  - No range check; pc advances freely.
  - fetch_fault is constant 0.

Test Plan:
- Reset, then imem holds 00500093, 00A00113, 002081B3 at words 0–2, id_ready=1 → id_valid rises 1 cycle after reset. Outputs are (pc 0x0, 00500093), (0x4, 00A00113), (0x8, 002081B3) on consecutive cycles, with no gaps.
- id_ready=0 for 10 cycles after reset → fetch pushes 4 entries and then pc stalls at 0x10; imem_addr stays 0x10. Release id_ready → PCs 0x0, 0x4, 0x8, 0xC drain in order, then 0x10 follows without a gap.
- FIFO full (PCs 0x0–0xC), then redirect_valid=1 with redirect_pc=0x42 while id_ready=1 → the following cycle shows id_valid=0 and imem_addr=0x40. The next cycle shows id_valid=1 and id_pc=0x40; no stale entry ever appears.
- Redirect to 0xFFFF_FFFC, id_ready=1 → id_pc sequence 0xFFFF_FFFC, then 0x0000_0000 (wrap). Requires FETCH_BOUND_CHECK_EN undefined.
- FETCH_BOUND_CHECK_EN defined, IMEM_WORDS=4, id_ready=1 → PCs 0x0–0xC delivered, then fetch_fault=1 and pc stays at 0x10. Redirect to 0x0 clears fetch_fault the next cycle.
- rst asserted for 1 cycle while 3 entries are buffered and pc=0x20 → next cycle id_valid=0, imem_addr=RESET_PC, fetch_fault=0.
